sys_irq_responder: RTL and testbench
====================================

// Module: sys_irq_responder
// PURPOSE
//  Peripheral-card interrupt responder for the 6809 system bus; far end of CPU card's IRQ_B / IACK_B handshake.
//  Edge-latches up to 7 device requests, masks them, pulls IRQ_B low, and supplies the vector bytes during IACK cycles.
//  Also exposes 4 control registers through the CSIO_B I/O select.
//  All bus inputs are synchronised into HSCLK; bus cycles end on the synchronised ECLK falling edge.
// PARAMETERS
//  NSRC         6   number of request inputs, 1..7; id 7 is reserved for spurious
//  SYNC_STAGES  2   synchroniser depth for ECLK, IRQ_SRC, CSIO_B, IACK_B (>=2)
// PORTS
//  HSCLK    in   1     block clock, >=4x ECLK
//  RST      in   1     asynchronous, active-high reset
//  ECLK     in   1     6809 E clock (asynchronous to HSCLK)
//  RNW      in   1     bus read/not-write
//  CSIO_B   in   1     I/O select for this block, active low
//  IACK_B   in   1     vector-fetch acknowledge from CPU card, active low
//  A        in   2     A[1:0]: register select; A[0] selects vector byte during IACK
//  DIN      in   8     bus write data
//  DOUT     out  8     bus read data
//  DOE      out  1     data bus drive enable, active high
//  IRQ_SRC  in   NSRC  device requests; each rising edge latches the request
//  IRQ_OE   out  1     high = pull IRQ_B low (external open-drain driver)
// BEHAVIOUR
//  - Reset values: PEND=0, MASK=0x00, VECHI=0xFF, VECLO=0xF0, DOUT=0, DOE=0, IRQ_OE=0, FSM=IDLE.
//    All synchroniser and edge-detect flops also reset.
//  - Register map, valid when CSIO_B=0 && IACK_B=1 (IACK has priority if both are low):
//    0 PEND   R; W1C. Written 1s clear bits.
//    1 MASK   R/W. 1 = source enabled.
//    2 VECHI  R/W.
//    3 VECLO  R/W. Only bits [7:4] are stored; reads return {VECLO[7:4],4'b0}.
//    Bits >= NSRC in PEND and MASK read as 0.
//  - Writes commit on the HSCLK after the synchronised ECLK falling edge (DIN is sampled there).
//  - Reads: DOE=1 and DOUT valid while the select is low, RNW=1 and synchronised ECLK=1.
//    DOE drops within 1 HSCLK of ECLK falling.
//  - Request path: a synchronised rising edge on IRQ_SRC[i] sets PEND[i] on the next HSCLK.
//    An edge and a W1C of the same bit in the same HSCLK: the set wins.
//  - IRQ_OE = |(PEND & MASK), registered, so there is 1 HSCLK latency after PEND/MASK change.
//  - Priority: the lowest index pending and enabled source wins. Resulting id = 0..NSRC-1, or 7 if none.
//  - Vector FSM (IACK cycles; the 6809 fetches hi byte with A0=0, then lo byte with A0=1):
//    IDLE   : IACK_B=0 && A0=0 && ECLK=1 -> freeze WIN=id.
//             DOUT=VECHI, DOE=1 while ECLK=1.
//             ECLK fall -> HI_DONE.
//    HI_DONE: IACK_B=0 && A0=1 && ECLK=1 -> DOUT={VECLO[7:4],WIN,1'b0}, DOE=1.
//             ECLK fall -> ACK (1 HSCLK).
//             IACK_B=0 && A0=0 -> repeated hi fetch: re-serve VECHI, keep WIN.
//    ACK    : optional PEND clear (see CONFIGURATION), -> IDLE.
//  - Hi-byte cycle ending with IACK_B high (aborted sequence): HI_DONE -> IDLE on the next non-IACK cycle end.
//    PEND is untouched.
//  - IACK_B=0 with A0=1 while in IDLE: serve lo byte using the live id; no clear.
//  - WIN stays frozen across the sequence, so new higher-priority edges do not change the lo byte.
//    Those edges still latch in PEND.
//  - Spurious vector (no winner): id field 7 = 3'b111, giving lo byte {VECLO[7:4],4'b1110}.
//  - RST mid-cycle: outputs drop immediately; the FSM returns to IDLE; latched requests are lost.
// CONFIGURATION
//  - IRQ_AUTOCLR_EN defined: in ACK, PEND[WIN] is cleared unless WIN==7.
//    A source edge in the same HSCLK re-sets the bit (set wins).
//  - IRQ_AUTOCLR_EN undefined: ACK clears nothing; software must W1C PEND in its handler.
//  - Both builds: identical register map and timing.
// TESTING
//  1. Reset, then read regs 0..3 -> 0x00, 0x00, 0xFF, 0xF0; IRQ_OE=0.
//  2. MASK=0x05, pulse IRQ_SRC[2] -> PEND=0x04, IRQ_OE=1.
//     Then W1C 0x04 -> PEND=0x00, IRQ_OE=0.
//  3. MASK=0x3F, VECHI=0xFE, VECLO=0x30, pulse src 4 then src 1.
//     IACK hi/lo -> 0xFE, 0x32.
//     AUTOCLR build: PEND 0x12->0x10, IRQ_OE stays 1. Non-AUTOCLR build: PEND stays 0x12.
//  4. Src 3 pending; hi fetch; pulse src 0 before lo fetch.
//     -> lo byte id=3 (0x36 with VECLO=0x30); PEND has bit 0 set.
//  5. IACK sequence with MASK=0 and PEND=0 -> lo byte 0x3E; no PEND change; FSM returns to IDLE.
//  6. Edge on src 5 in the same HSCLK as a W1C of bit 5 -> PEND[5]=1.
//     Assert RST during an IACK lo cycle -> DOE=0 immediately; PEND=0.

Source files
------------

// File: rtl/sys_irq_responder.sv
// sys_irq_responder
//   Interrupt responder at the peripheral end of the 6809 IRQ_B / IACK_B
//   handshake. Up to NSRC device requests are edge-latched into PEND and
//   gated by MASK. IRQ_OE is driven whenever an enabled request is pending.
//   During IACK cycles the block serves a two-byte vector. The high byte is
//   VECHI. The low byte is {VECLO[7:4], winner id, 1'b0}. Four control
//   registers are reachable through CSIO_B.
//
//   Optional build macro IRQ_AUTOCLR_EN: when defined, completing the
//   low-byte fetch clears the PEND bit of the source that was vectored.
//   Without it, software clears PEND through W1C writes.
//
// Ports
//   HSCLK    in        block clock, at least 4x ECLK
//   RST      in        asynchronous active-high reset
//   ECLK     in        6809 E clock, asynchronous to HSCLK
//   RNW      in        bus read/not-write
//   CSIO_B   in        register select, active low
//   IACK_B   in        vector-fetch acknowledge, active low
//   A        in  [1:0] register select; A[0] picks the vector byte in IACK
//   DIN      in  [7:0] bus write data
//   DOUT     out [7:0] bus read data
//   DOE      out       data bus drive enable
//   IRQ_SRC  in  [NSRC-1:0] device requests, rising-edge sensitive
//   IRQ_OE   out       high pulls IRQ_B low through the external driver
module sys_irq_responder #(
    parameter int NSRC        = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic            HSCLK,
    input  logic            RST,
    input  logic            ECLK,
    input  logic            RNW,
    input  logic            CSIO_B,
    input  logic            IACK_B,
    input  logic [1:0]      A,
    input  logic [7:0]      DIN,
    output logic [7:0]      DOUT,
    output logic            DOE,
    input  logic [NSRC-1:0] IRQ_SRC,
    output logic            IRQ_OE
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HI_DONE = 2'd1,
        ACK     = 2'd2
    } state_t;

    state_t state;

    logic [SYNC_STAGES-1:0] eclk_sh;
    logic [SYNC_STAGES-1:0] csio_sh;
    logic [SYNC_STAGES-1:0] iack_sh;
    logic [NSRC-1:0]        src_sh [SYNC_STAGES];
    logic                   eclk_d;
    logic [NSRC-1:0]        src_d;

    logic                   eclk_s;
    logic                   csio_s;
    logic                   iack_s;
    logic [NSRC-1:0]        src_s;
    logic                   eclk_fall;
    logic [NSRC-1:0]        src_rise;

    logic [NSRC-1:0]        pend;
    logic [NSRC-1:0]        mask;
    logic [7:0]             vechi;
    logic [3:0]             veclo;
    logic [2:0]             win;
    logic [2:0]             live_id;

    logic                   wr_en;
    logic                   reg_rd;
    logic                   iack_cyc;
    logic [7:0]             rd_data;
    logic [NSRC-1:0]        w1c;
    logic [NSRC-1:0]        autoclr;

    // Synchronisers and edge-detect history. The select lines reset to
    // their inactive (high) level so no bus cycle appears after reset.
    // The request synchroniser has the same depth as the ECLK one. An
    // IRQ_SRC edge and an ECLK fall that arrive together are therefore
    // seen in the same HSCLK.
    always_ff @(posedge HSCLK or posedge RST) begin
        if (RST) begin
            eclk_sh <= '0;
            csio_sh <= '1;
            iack_sh <= '1;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                src_sh[i] <= '0;
            end
            eclk_d  <= 1'b0;
            src_d   <= '0;
        end else begin
            eclk_sh   <= {eclk_sh[SYNC_STAGES-2:0], ECLK};
            csio_sh   <= {csio_sh[SYNC_STAGES-2:0], CSIO_B};
            iack_sh   <= {iack_sh[SYNC_STAGES-2:0], IACK_B};
            src_sh[0] <= IRQ_SRC;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                src_sh[i] <= src_sh[i-1];
            end
            eclk_d    <= eclk_s;
            src_d     <= src_s;
        end
    end

    assign eclk_s    = eclk_sh[SYNC_STAGES-1];
    assign csio_s    = csio_sh[SYNC_STAGES-1];
    assign iack_s    = iack_sh[SYNC_STAGES-1];
    assign src_s     = src_sh[SYNC_STAGES-1];
    assign eclk_fall = eclk_d & ~eclk_s;
    assign src_rise  = src_s & ~src_d;

    // IACK takes priority over the register select when both are low.
    assign iack_cyc = ~iack_s & eclk_s;
    assign reg_rd   = ~csio_s & iack_s & RNW & eclk_s;
    assign wr_en    = eclk_fall & ~csio_s & iack_s & ~RNW;

    // The lowest-numbered source that is pending and enabled wins.
    // The value 7 means there is no winner, which gives the spurious vector.
    always_comb begin
        live_id = 3'd7;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (pend[i] && mask[i]) begin
                live_id = 3'(i);
            end
        end
    end

    always_comb begin
        rd_data = 8'h00;
        case (A)
            2'd0:    rd_data = 8'(pend);
            2'd1:    rd_data = 8'(mask);
            2'd2:    rd_data = vechi;
            default: rd_data = {veclo, 4'b0000};
        endcase
    end

    // Clear masks for PEND: software W1C, and the optional clear when a
    // vector fetch completes. A request edge in the same HSCLK still sets
    // its bit, because src_rise is ORed in after the clears.
    always_comb begin
        w1c     = '0;
        autoclr = '0;
        if (wr_en && (A == 2'd0)) begin
            w1c = DIN[NSRC-1:0];
        end
`ifdef IRQ_AUTOCLR_EN
        if (state == ACK) begin
            for (int i = 0; i < NSRC; i++) begin
                if (win == 3'(i)) begin
                    autoclr[i] = 1'b1;
                end
            end
        end
`endif
    end

    // Control registers and the registered IRQ_B request.
    always_ff @(posedge HSCLK or posedge RST) begin
        if (RST) begin
            pend   <= '0;
            mask   <= '0;
            vechi  <= 8'hFF;
            veclo  <= 4'hF;
            IRQ_OE <= 1'b0;
        end else begin
            pend   <= (pend & ~w1c & ~autoclr) | src_rise;
            IRQ_OE <= |(pend & mask);
            if (wr_en) begin
                case (A)
                    2'd1:    mask  <= DIN[NSRC-1:0];
                    2'd2:    vechi <= DIN;
                    2'd3:    veclo <= DIN[7:4];
                    default: ;
                endcase
            end
        end
    end

    // Vector FSM and the registered bus outputs. WIN is captured during the
    // high-byte fetch. The low byte then names the same source even if a
    // higher-priority request arrives between the two fetches.
    always_ff @(posedge HSCLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            win   <= 3'd7;
            DOUT  <= 8'h00;
            DOE   <= 1'b0;
        end else begin
            DOE  <= 1'b0;
            DOUT <= 8'h00;
            if (reg_rd) begin
                DOE  <= 1'b1;
                DOUT <= rd_data;
            end
            unique case (state)
                IDLE: begin
                    if (iack_cyc) begin
                        DOE <= 1'b1;
                        if (!A[0]) begin
                            win  <= live_id;
                            DOUT <= vechi;
                        end else begin
                            DOUT <= {veclo, live_id, 1'b0};
                        end
                    end
                    if (eclk_fall && !iack_s && !A[0]) begin
                        state <= HI_DONE;
                    end
                end
                HI_DONE: begin
                    if (iack_cyc) begin
                        DOE  <= 1'b1;
                        DOUT <= A[0] ? {veclo, win, 1'b0} : vechi;
                    end
                    // A cycle that ends without IACK means the CPU
                    // abandoned the sequence.
                    if (eclk_fall) begin
                        if (iack_s) begin
                            state <= IDLE;
                        end else if (A[0]) begin
                            state <= ACK;
                        end
                    end
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sys_irq_responder.sv
// tb_sys_irq_responder
//   Directed bench for sys_irq_responder using the default parameters
//   (NSRC=6, SYNC_STAGES=2). Bus cycles are driven slowly relative to HSCLK.
//   Each expected value is a hand-computed constant.
module tb_sys_irq_responder;

    logic       HSCLK = 1'b0;
    logic       RST;
    logic       ECLK;
    logic       RNW;
    logic       CSIO_B;
    logic       IACK_B;
    logic [1:0] A;
    logic [7:0] DIN;
    logic [7:0] DOUT;
    logic       DOE;
    logic [5:0] irq_src;
    logic       IRQ_OE;

    int check_count = 0;
    int error_count = 0;

    sys_irq_responder #(
        .NSRC        (6),
        .SYNC_STAGES (2)
    ) dut (
        .HSCLK   (HSCLK),
        .RST     (RST),
        .ECLK    (ECLK),
        .RNW     (RNW),
        .CSIO_B  (CSIO_B),
        .IACK_B  (IACK_B),
        .A       (A),
        .DIN     (DIN),
        .DOUT    (DOUT),
        .DOE     (DOE),
        .IRQ_SRC (irq_src),
        .IRQ_OE  (IRQ_OE)
    );

    always #5 HSCLK = ~HSCLK;

    task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", tag, actual, expected);
        end
    endtask

    // One complete bus cycle: the bus lines are set up while ECLK is low,
    // then ECLK goes high, the read data is sampled, and ECLK falls. The
    // bits in src_at_fall are raised at the same instant ECLK falls.
    task automatic applyStimulus(input logic rnw, input logic csio_b, input logic iack_b,
                                 input logic [1:0] a, input logic [7:0] din,
                                 input logic [5:0] src_at_fall,
                                 output logic [7:0] rd_data, output logic rd_oe);
        @(negedge HSCLK);
        RNW = rnw; CSIO_B = csio_b; IACK_B = iack_b; A = a; DIN = din;
        repeat (4) @(negedge HSCLK);
        ECLK = 1'b1;
        repeat (8) @(negedge HSCLK);
        rd_data = DOUT;
        rd_oe   = DOE;
        ECLK    = 1'b0;
        irq_src = irq_src | src_at_fall;
        repeat (6) @(negedge HSCLK);
        CSIO_B = 1'b1; IACK_B = 1'b1; RNW = 1'b1;
        irq_src = irq_src & ~src_at_fall;
        repeat (4) @(negedge HSCLK);
    endtask

    task automatic regWrite(input logic [1:0] a, input logic [7:0] d);
        logic [7:0] unused_d;
        logic       unused_oe;
        applyStimulus(1'b0, 1'b0, 1'b1, a, d, 6'h00, unused_d, unused_oe);
    endtask

    task automatic regRead(input logic [1:0] a, output logic [7:0] d, output logic oe);
        applyStimulus(1'b1, 1'b0, 1'b1, a, 8'h00, 6'h00, d, oe);
    endtask

    task automatic iackFetch(input logic a0, output logic [7:0] d);
        logic oe;
        applyStimulus(1'b1, 1'b1, 1'b0, {1'b0, a0}, 8'h00, 6'h00, d, oe);
    endtask

    task automatic pulseSource(input int idx);
        @(negedge HSCLK);
        irq_src[idx] = 1'b1;
        repeat (4) @(negedge HSCLK);
        irq_src[idx] = 1'b0;
        repeat (4) @(negedge HSCLK);
    endtask

    initial begin
        logic [7:0] d;
        logic       oe;

        RST = 1'b1; ECLK = 1'b0; RNW = 1'b1; CSIO_B = 1'b1; IACK_B = 1'b1;
        A = 2'd0; DIN = 8'h00; irq_src = 6'h00;
        repeat (3) @(negedge HSCLK);
        RST = 1'b0;
        @(negedge HSCLK);

        // Reset values
        checkOutput("reset_doe", {7'd0, DOE}, 8'h00);
        checkOutput("reset_dout", DOUT, 8'h00);
        checkOutput("reset_irq_oe", {7'd0, IRQ_OE}, 8'h00);
        regRead(2'd0, d, oe); checkOutput("reset_pend", d, 8'h00);
        checkOutput("read_doe", {7'd0, oe}, 8'h01);
        checkOutput("doe_drop", {7'd0, DOE}, 8'h00);
        regRead(2'd1, d, oe); checkOutput("reset_mask", d, 8'h00);
        regRead(2'd2, d, oe); checkOutput("reset_vechi", d, 8'hFF);
        regRead(2'd3, d, oe); checkOutput("reset_veclo", d, 8'hF0);

        // Masked request raises IRQ_OE, and W1C drops it
        regWrite(2'd1, 8'h05);
        pulseSource(2);
        regRead(2'd0, d, oe); checkOutput("t2_pend", d, 8'h04);
        checkOutput("t2_irq_oe", {7'd0, IRQ_OE}, 8'h01);
        regWrite(2'd0, 8'h04);
        regRead(2'd0, d, oe); checkOutput("t2_pend_clr", d, 8'h00);
        checkOutput("t2_irq_oe_clr", {7'd0, IRQ_OE}, 8'h00);

        // Vector fetch with two pending sources; lowest index wins
        regWrite(2'd1, 8'h3F);
        regWrite(2'd2, 8'hFE);
        regWrite(2'd3, 8'h3A);
        regRead(2'd3, d, oe); checkOutput("t3_veclo_rd", d, 8'h30);
        pulseSource(4);
        pulseSource(1);
        regRead(2'd0, d, oe); checkOutput("t3_pend", d, 8'h12);
        iackFetch(1'b0, d); checkOutput("t3_hi", d, 8'hFE);
        iackFetch(1'b1, d); checkOutput("t3_lo", d, 8'h32);
        regRead(2'd0, d, oe);
`ifdef IRQ_AUTOCLR_EN
        checkOutput("t3_pend_after", d, 8'h10);
`else
        checkOutput("t3_pend_after", d, 8'h12);
`endif
        checkOutput("t3_irq_oe", {7'd0, IRQ_OE}, 8'h01);
        regWrite(2'd0, 8'hFF);

        // WIN stays frozen across a new higher-priority edge
        pulseSource(3);
        iackFetch(1'b0, d); checkOutput("t4_hi", d, 8'hFE);
        pulseSource(0);
        iackFetch(1'b1, d); checkOutput("t4_lo", d, 8'h36);
        regRead(2'd0, d, oe);
`ifdef IRQ_AUTOCLR_EN
        checkOutput("t4_pend", d, 8'h01);
`else
        checkOutput("t4_pend", d, 8'h09);
`endif
        regWrite(2'd0, 8'hFF);

        // Spurious vector, then FSM back in IDLE (live id used for lo byte)
        regWrite(2'd1, 8'h00);
        iackFetch(1'b0, d); checkOutput("t5_hi", d, 8'hFE);
        iackFetch(1'b1, d); checkOutput("t5_lo_spurious", d, 8'h3E);
        regRead(2'd0, d, oe); checkOutput("t5_pend", d, 8'h00);
        regWrite(2'd1, 8'h05);
        pulseSource(2);
        iackFetch(1'b1, d); checkOutput("t5_idle_lo", d, 8'h34);
        // An aborted sequence followed by a live-id lo fetch
        iackFetch(1'b0, d); checkOutput("t5_abort_hi", d, 8'hFE);
        regRead(2'd1, d, oe); checkOutput("t5_abort_mask", d, 8'h05);
        pulseSource(0);
        iackFetch(1'b1, d); checkOutput("t5_abort_lo", d, 8'h30);
        regRead(2'd0, d, oe); checkOutput("t5_abort_pend", d, 8'h05);
        regWrite(2'd0, 8'hFF);

        // An edge and a W1C of the same bit in one HSCLK: the set wins
        pulseSource(5);
        regRead(2'd0, d, oe); checkOutput("t6_pend_pre", d, 8'h20);
        applyStimulus(1'b0, 1'b0, 1'b1, 2'd0, 8'h20, 6'h20, d, oe);
        regRead(2'd0, d, oe); checkOutput("t6_set_wins", d, 8'h20);

        // Reset asserted during the lo-byte cycle
        iackFetch(1'b0, d); checkOutput("t6_hi", d, 8'hFE);
        @(negedge HSCLK);
        RNW = 1'b1; IACK_B = 1'b0; A = 2'd1;
        repeat (4) @(negedge HSCLK);
        ECLK = 1'b1;
        repeat (8) @(negedge HSCLK);
        checkOutput("t6_lo_doe", {7'd0, DOE}, 8'h01);
        #2 RST = 1'b1;
        #1;
        checkOutput("t6_rst_doe", {7'd0, DOE}, 8'h00);
        checkOutput("t6_rst_dout", DOUT, 8'h00);
        ECLK = 1'b0; IACK_B = 1'b1; A = 2'd0;
        repeat (3) @(negedge HSCLK);
        RST = 1'b0;
        repeat (4) @(negedge HSCLK);
        regRead(2'd0, d, oe); checkOutput("t6_rst_pend", d, 8'h00);
        checkOutput("t6_rst_irq_oe", {7'd0, IRQ_OE}, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
